mc_ctrl: RTL and testbench

- Multi-cycle MIPS control FSM that sequences the shared single ALU and its operand muxes (ALU source A, 6-input ALU source B mux), PC, IR, register file and unified memory.
- Sits beside the datapath: takes opcode/funct/zero from the datapath and emits per-state enables and mux selects.
- Executes one instruction in 3–5 states, plus wait states while memory is not ready.

---
 rtl/mc_defs_pkg.sv | 51 +++++
 rtl/mc_decode.sv | 22 ++
 rtl/mc_ctrl.sv | 148 ++++++++++++++
 tb/tb_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs_pkg.sv
// mc_defs: shared state, opcode/funct and mux-select encodings for the multi-cycle MIPS controller
package mc_defs;
   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_R  = 4'd2,
      S_EXE_I  = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_R   = 4'd7,
      S_WB_I   = 4'd8,
      S_WB_LW  = 4'd9,
      S_BR     = 4'd10,
      S_JMP    = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam int SRCB_REG  = 0;
   localparam int SRCB_FOUR = 1;
   localparam int SRCB_SEXT = 2;
   localparam int SRCB_BR   = 3;
   localparam int SRCB_ZEXT = 4;
   localparam int SRCB_LUI  = 5;

   localparam int ALUOP_ADD   = 0;
   localparam int ALUOP_SUB   = 1;
   localparam int ALUOP_FUNCT = 2;
   localparam int ALUOP_LOGIC = 3;

   localparam logic [1:0] PCSRC_ALU = 2'd0;
   localparam logic [1:0] PCSRC_OUT = 2'd1;
   localparam logic [1:0] PCSRC_JMP = 2'd2;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct classifier for the multi-cycle controller
module mc_decode
   import mc_defs::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       is_r,
   output logic       is_lw,
   output logic       is_sw,
   output logic       is_imm,
   output logic       is_br,
   output logic       is_j,
   output logic       illegal
);
   assign is_r    = opcode == OP_RTYPE && funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
   assign is_lw   = opcode == OP_LW;
   assign is_sw   = opcode == OP_SW;
   assign is_imm  = opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI};
   assign is_br   = opcode inside {OP_BEQ, OP_BNE};
   assign is_j    = opcode == OP_J;
   assign illegal = !(is_r || is_lw || is_sw || is_imm || is_br || is_j);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM driving PC, IR, regfile, memory and ALU mux selects.
// Define MC_ILLEGAL_TRAP_EN to trap illegal instructions in S_TRAP and expose the illegal output.
module mc_ctrl
   import mc_defs::*;
#(
   parameter int SRCB_W  = 3,
   parameter int ALUOP_W = 2
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_source,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [SRCB_W-1:0]  alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic               illegal,
`endif
   output logic [3:0]         state_o
);
`ifdef MC_ILLEGAL_TRAP_EN
   localparam state_t ILL_NEXT = S_TRAP;
`else
   localparam state_t ILL_NEXT = S_IF;
`endif
   state_t state, nxt;
   logic is_r, is_lw, is_sw, is_imm, is_br, is_j, dec_illegal;

   mc_decode u_dec (
      .opcode (opcode),
      .funct  (funct),
      .is_r   (is_r),
      .is_lw  (is_lw),
      .is_sw  (is_sw),
      .is_imm (is_imm),
      .is_br  (is_br),
      .is_j   (is_j),
      .illegal(dec_illegal)
   );

   always_ff @(posedge clk)
      state <= reset ? S_IF : nxt;

   always_comb begin
      nxt = S_IF;
      case (state)
         S_IF:     nxt = mem_ready ? S_ID : S_IF;
         S_ID:     nxt = dec_illegal ? ILL_NEXT :
                         is_r ? S_EXE_R :
                         (is_lw || is_sw) ? S_ADDR :
                         is_imm ? S_EXE_I :
                         is_br ? S_BR :
                         is_j ? S_JMP : S_IF;
         S_EXE_R:  nxt = S_WB_R;
         S_EXE_I:  nxt = S_WB_I;
         S_ADDR:   nxt = is_sw ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: nxt = mem_ready ? S_WB_LW : S_MEM_RD;
         S_MEM_WR: nxt = mem_ready ? S_IF : S_MEM_WR;
         S_TRAP:   nxt = S_TRAP;
         default:  nxt = S_IF;
      endcase
   end

   // Everything is forced to zero while reset is high, whatever state the register still holds.
   always_comb begin
      pc_write   = 1'b0;
      pc_source  = PCSRC_ALU;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_W'(SRCB_REG);
      alu_op     = ALUOP_W'(ALUOP_ADD);
      if (!reset)
         case (state)
            S_IF: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_W'(SRCB_FOUR);
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_ID: alu_src_b = SRCB_W'(SRCB_BR);
            S_EXE_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_W'(ALUOP_FUNCT);
            end
            S_EXE_I: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_W'(ALUOP_LOGIC);
               alu_src_b = opcode == OP_LUI  ? SRCB_W'(SRCB_LUI) :
                           opcode == OP_ADDI ? SRCB_W'(SRCB_SEXT) : SRCB_W'(SRCB_ZEXT);
            end
            S_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_W'(SRCB_SEXT);
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_WB_I: reg_write = 1'b1;
            S_WB_LW: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_BR: begin
               alu_src_a = 1'b1;
               alu_op    = ALUOP_W'(ALUOP_SUB);
               pc_source = PCSRC_OUT;
            end
            S_JMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JMP;
            end
            default: ;
         endcase
   end

   assign pc_write_cond = !reset && state == S_BR && (opcode == OP_BEQ ? zero : !zero);
   assign state_o = state;
`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal = state == S_TRAP;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench comparing mc_ctrl against an instruction-level path model
module tb_mc_ctrl;
   import mc_defs::*;

   logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
   logic [5:0] opcode = '0, funct = '0;
   logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] pc_source, alu_op;
   logic [2:0] alu_src_b;
   logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
   logic illegal;
`endif
   int checks = 0, errors = 0;

   typedef struct packed {
      logic       pc_write, pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [2:0] alu_src_b;
      logic [1:0] alu_op;
   } outs_t;
   typedef struct {
      state_t st;
      logic   mr;
      logic   z;
   } step_t;

   outs_t act;
   step_t path[$];

   assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

   always #5 clk = ~clk;

   mc_ctrl #(.SRCB_W(3), .ALUOP_W(2)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal(illegal),
`endif
      .state_o(state_o)
   );

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic legal_r(input logic [5:0] f);
      return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
   endfunction

   // Per-state control word taken directly from the state table, numeric codes spelled out.
   function automatic outs_t expect_out(input state_t s, input logic [5:0] op, input logic z, input logic mr);
      outs_t e = '0;
      case (s)
         S_IF:     begin e.mem_read = 1; e.alu_src_b = 3'd1; e.ir_write = mr; e.pc_write = mr; end
         S_ID:     e.alu_src_b = 3'd3;
         S_EXE_R:  begin e.alu_src_a = 1; e.alu_op = 2'd2; end
         S_EXE_I:  begin
            e.alu_src_a = 1; e.alu_op = 2'd3;
            e.alu_src_b = op == 6'h08 ? 3'd2 : op == 6'h0f ? 3'd5 : 3'd4;
         end
         S_ADDR:   begin e.alu_src_a = 1; e.alu_src_b = 3'd2; end
         S_MEM_RD: begin e.mem_read = 1; e.i_or_d = 1; end
         S_MEM_WR: begin e.mem_write = 1; e.i_or_d = 1; end
         S_WB_R:   begin e.reg_write = 1; e.reg_dst = 1; end
         S_WB_I:   e.reg_write = 1;
         S_WB_LW:  begin e.reg_write = 1; e.mem_to_reg = 1; end
         S_BR:     begin
            e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_source = 2'd1;
            e.pc_write_cond = op == 6'h04 ? z : !z;
         end
         S_JMP:    begin e.pc_write = 1; e.pc_source = 2'd2; end
         default:  ;
      endcase
      return e;
   endfunction

   task automatic push(input state_t s, input logic mr, input logic z);
      path.push_back('{st: s, mr: mr, z: z});
   endtask

   // Expected state sequence of one instruction, including the requested memory wait cycles.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w_if, input int w_mem);
      repeat (w_if) push(S_IF, 1'b0, rb());
      push(S_IF, 1'b1, rb());
      push(S_ID, rb(), rb());
      if (op == 6'h00 && legal_r(fn)) begin
         push(S_EXE_R, rb(), rb());
         push(S_WB_R, rb(), rb());
      end else if (op == 6'h23) begin
         push(S_ADDR, rb(), rb());
         repeat (w_mem) push(S_MEM_RD, 1'b0, rb());
         push(S_MEM_RD, 1'b1, rb());
         push(S_WB_LW, rb(), rb());
      end else if (op == 6'h2b) begin
         push(S_ADDR, rb(), rb());
         repeat (w_mem) push(S_MEM_WR, 1'b0, rb());
         push(S_MEM_WR, 1'b1, rb());
      end else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0f}) begin
         push(S_EXE_I, rb(), rb());
         push(S_WB_I, rb(), rb());
      end else if (op inside {6'h04, 6'h05}) begin
         push(S_BR, rb(), z);
      end else if (op == 6'h02) begin
         push(S_JMP, rb(), rb());
      end else begin
`ifdef MC_ILLEGAL_TRAP_EN
         repeat (12) push(S_TRAP, rb(), rb());
`endif
      end
   endtask

   task automatic walk(input logic [5:0] op, input logic [5:0] fn, input string tag);
      outs_t e;
      foreach (path[i]) begin
         @(negedge clk);
         reset = 1'b0; opcode = op; funct = fn; mem_ready = path[i].mr; zero = path[i].z;
         #1;
         e = expect_out(path[i].st, op, path[i].z, path[i].mr);
         checks++;
         if (state_o !== 4'(path[i].st)) begin
            errors++;
            $display("FAIL %s state step %0d: got %0d want %0d", tag, i, state_o, 4'(path[i].st));
         end
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s outputs step %0d state %0d: got %h want %h", tag, i, state_o, act, e);
         end
`ifdef MC_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== (path[i].st == S_TRAP)) begin
            errors++;
            $display("FAIL %s illegal step %0d: got %b want %b", tag, i, illegal, path[i].st == S_TRAP);
         end
`endif
      end
      path.delete();
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int w_if, input int w_mem, input string tag);
      build(op, fn, z, w_if, w_mem);
      walk(op, fn, tag);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      checks++;
      if (state_o !== 4'(S_IF) || act !== expect_out(S_IF, opcode, zero, 1'b0)) begin
         errors++;
         $display("FAIL %s idle: got state %0d outs %h want state %0d outs %h", tag, state_o, act, 4'(S_IF), expect_out(S_IF, opcode, zero, 1'b0));
      end
   endtask

   task automatic test_reset();
      repeat (3) begin
         @(negedge clk);
         reset = 1'b1; mem_ready = 1'b1;
         #1;
         checks++;
         if (act !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h want %h", act, outs_t'('0));
         end
         checks++;
         if (state_o !== 4'(S_IF)) begin
            errors++;
            $display("FAIL reset state: got %0d want %0d", state_o, 4'(S_IF));
         end
      end
   endtask

   task automatic test_rtype();
      run(6'h00, 6'h20, 1'b0, 0, 0, "rtype_add");
   endtask

   task automatic test_lw_wait();
      run(6'h23, 6'h00, 1'b0, 0, 2, "lw_wait");
   endtask

   task automatic test_branch();
      run(6'h04, 6'h00, 1'b1, 0, 0, "beq_z1");
      run(6'h04, 6'h00, 1'b0, 0, 0, "beq_z0");
      run(6'h05, 6'h00, 1'b1, 0, 0, "bne_z1");
      run(6'h05, 6'h00, 1'b0, 0, 0, "bne_z0");
   endtask

   task automatic test_imm();
      run(6'h0d, 6'h00, 1'b0, 0, 0, "ori");
      run(6'h0f, 6'h00, 1'b0, 0, 0, "lui");
      run(6'h08, 6'h00, 1'b0, 0, 0, "addi");
      run(6'h0c, 6'h00, 1'b0, 0, 0, "andi");
   endtask

   task automatic test_random();
      logic [5:0] op, fn;
`ifdef MC_ILLEGAL_TRAP_EN
      int top = 13;
`else
      int top = 15;
`endif
      for (int n = 0; n < 40; n++) begin
         fn = 6'($urandom);
         case ($urandom_range(0, top))
            0:  begin op = 6'h00; fn = 6'h20; end
            1:  begin op = 6'h00; fn = 6'h22; end
            2:  begin op = 6'h00; fn = 6'h24; end
            3:  begin op = 6'h00; fn = 6'h25; end
            4:  begin op = 6'h00; fn = 6'h2a; end
            5:  op = 6'h23;
            6:  op = 6'h2b;
            7:  op = 6'h08;
            8:  op = 6'h0c;
            9:  op = 6'h0d;
            10: op = 6'h0f;
            11: op = 6'h04;
            12: op = 6'h05;
            13: op = 6'h02;
            14: begin op = 6'h00; fn = 6'h00; end
            default: op = 6'h3f;
         endcase
         run(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_reset_mem_wr();
      push(S_IF, 1'b1, 1'b0);
      push(S_ID, 1'b1, 1'b0);
      push(S_ADDR, 1'b1, 1'b0);
      push(S_MEM_WR, 1'b0, 1'b0);
      walk(6'h2b, 6'h00, "sw_pre_reset");
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || act !== '0) begin
         errors++;
         $display("FAIL reset_in_mem_wr outputs: got mem_write %b outs %h want 0 and %h", mem_write, act, outs_t'('0));
      end
      check_idle("after_mem_wr_reset");
   endtask

   task automatic test_illegal();
      run(6'h3f, 6'h00, 1'b0, 0, 0, "illegal_op");
`ifdef MC_ILLEGAL_TRAP_EN
      @(negedge clk);
      reset = 1'b1;
`endif
      check_idle("after_illegal");
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_branch();
      test_imm();
      test_random();
      test_reset_mem_wr();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
